// File: rtl/freq_pkg.sv
// Shared definitions for the frequency meter: FSM state encoding and default sizing.
package freq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam int unsigned DEF_GATE_CYCLES = 1000;
    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous input followed by a rising-edge detector.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_dly  <= r_sync[SYNC_STAGES-1];
        end
    end

    // Combinational so the edge is counted on the cycle it becomes visible.
    assign rise = r_sync[SYNC_STAGES-1] & ~r_dly;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous input over a fixed gate window and
// publishes the result with a one-cycle valid strobe.
module freq_meter
    import freq_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             frequency,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned       GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [GATE_W-1:0] r_gate_cnt;
    logic [CNT_W-1:0]  r_edge_cnt;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_count;
    logic              r_valid;
    logic              r_overflow;
    logic              r_busy;

    logic              w_rise;
    logic              w_last;
    logic              w_run;
    logic [CNT_W-1:0]  w_edge_nxt;
    logic              w_ovf_nxt;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (frequency),
        .rise (w_rise)
    );

    assign w_last = (r_gate_cnt == GATE_LAST);
    assign w_run  = (r_state == ST_MEASURE) && enable;

    // Saturating edge count; an increment attempted at full scale flags overflow.
    always_comb begin
        w_edge_nxt = r_edge_cnt;
        w_ovf_nxt  = r_ovf;
        if (w_rise) begin
            if (r_edge_cnt == CNT_MAX) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_edge_nxt = r_edge_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) w_state_nxt = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (!enable)     w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = enable ? ST_MEASURE : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters only advance inside a live window; every other state leaves them cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
        end else if (w_run) begin
            r_gate_cnt <= r_gate_cnt + GATE_W'(1);
            r_edge_cnt <= w_edge_nxt;
            r_ovf      <= w_ovf_nxt;
        end else begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
        end
    end

    // Results load on entry to DONE so valid, count and overflow appear together in that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid <= w_run && w_last;
            r_busy  <= (w_state_nxt == ST_MEASURE);
            if (w_run && w_last) begin
                r_count    <= w_edge_nxt;
                r_overflow <= w_ovf_nxt;
            end
        end
    end

    assign count    = r_count;
    assign valid    = r_valid;
    assign overflow = r_overflow;
    assign busy     = r_busy;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (16-bit and 4-bit counters) share one stimulus;
// expected window results are queued per instance and checked on each valid strobe.
module tb_freq_meter;

    localparam int unsigned GATE = 100;

    typedef struct packed {
        logic        chk;
        logic [15:0] cnt;
        logic        ovf;
    } exp_t;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        enable  = 1'b0;
    logic        freq_in = 1'b0;
    logic [15:0] count_a;
    logic        valid_a, ovf_a, busy_a;
    logic [3:0]  count_b;
    logic        valid_b, ovf_b, busy_b;

    int   half  = 0;
    logic level = 1'b0;
    int   ph    = 0;

    int checks = 0;
    int errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    int n_va = 0;
    int cyc = 0;
    int last_va_cyc = 0;
    int gap_a = 0;
    int busy_run = 0;
    int busy_len = 0;

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(16), .SYNC_STAGES(2)) u_dut_a (
        .clk(clk), .reset(rst_n), .enable(enable), .frequency(freq_in),
        .count(count_a), .valid(valid_a), .overflow(ovf_a), .busy(busy_a)
    );

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(4), .SYNC_STAGES(2)) u_dut_b (
        .clk(clk), .reset(rst_n), .enable(enable), .frequency(freq_in),
        .count(count_b), .valid(valid_b), .overflow(ovf_b), .busy(busy_b)
    );

    // Square-wave source: half = clk cycles per level; half = 0 holds 'level'.
    always @(negedge clk) begin
        if (half == 0) begin
            freq_in = level;
            ph = 0;
        end else if (ph >= half - 1) begin
            freq_in = ~freq_in;
            ph = 0;
        end else begin
            ph = ph + 1;
        end
    end

    always @(negedge clk) begin : mon
        exp_t e;
        cyc = cyc + 1;
        if (busy_a === 1'b1) begin
            busy_run = busy_run + 1;
        end else begin
            if (busy_run != 0) busy_len = busy_run;
            busy_run = 0;
        end
        if (valid_a === 1'b1) begin
            gap_a = cyc - last_va_cyc;
            last_va_cyc = cyc;
            n_va = n_va + 1;
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_a unexpected valid: count=%0d overflow=%0b", count_a, ovf_a);
            end else begin
                e = qa.pop_front();
                if (e.chk) begin
                    checks++;
                    if (count_a !== e.cnt || ovf_a !== e.ovf) begin
                        errors++;
                        $display("FAIL sb_a window: count=%0d overflow=%0b, required count=%0d overflow=%0b",
                                 count_a, ovf_a, e.cnt, e.ovf);
                    end
                end
            end
        end
        if (valid_b === 1'b1) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_b unexpected valid: count=%0d overflow=%0b", count_b, ovf_b);
            end else begin
                e = qb.pop_front();
                if (e.chk) begin
                    checks++;
                    if (count_b !== e.cnt[3:0] || ovf_b !== e.ovf) begin
                        errors++;
                        $display("FAIL sb_b window: count=%0d overflow=%0b, required count=%0d overflow=%0b",
                                 count_b, ovf_b, e.cnt[3:0], e.ovf);
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic chk, input logic [15:0] ca, input logic oa,
                            input logic [15:0] cb, input logic ob, input int n);
        for (int i = 0; i < n; i++) begin
            qa.push_back('{chk, ca, oa});
            qb.push_back('{chk, cb, ob});
        end
    endtask

    task automatic wait_valids(input int n, input string tag);
        int target;
        int budget;
        target = n_va + n;
        budget = (GATE + 2) * n + 50;
        while (n_va < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (n_va < target) begin
            errors++;
            $display("FAIL %s timeout: valids seen=%0d, required=%0d", tag, n_va, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({count_a, valid_a, ovf_a, busy_a} !== 19'd0) begin
            errors++;
            $display("FAIL reset_a: count=%0d valid=%0b ovf=%0b busy=%0b, required all 0",
                     count_a, valid_a, ovf_a, busy_a);
        end
        checks++;
        if ({count_b, valid_b, ovf_b, busy_b} !== 7'd0) begin
            errors++;
            $display("FAIL reset_b: count=%0d valid=%0b ovf=%0b busy=%0b, required all 0",
                     count_b, valid_b, ovf_b, busy_b);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_period2();
        half = 1;
        repeat (8) @(negedge clk);
        push_exp(1'b1, 16'd50, 1'b0, 16'd15, 1'b1, 3);
        enable = 1'b1;
        wait_valids(3, "period2");
        checks++;
        if (gap_a !== 101) begin
            errors++;
            $display("FAIL period2_spacing: gap=%0d, required 101", gap_a);
        end
    endtask

    task automatic test_period20();
        half = 10;
        push_exp(1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1);
        push_exp(1'b1, 16'd5, 1'b0, 16'd5, 1'b0, 2);
        wait_valids(3, "period20");
        checks++;
        if (gap_a !== 101) begin
            errors++;
            $display("FAIL period20_spacing: gap=%0d, required 101", gap_a);
        end
    endtask

    task automatic test_period10();
        half = 5;
        push_exp(1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1);
        push_exp(1'b1, 16'd10, 1'b0, 16'd10, 1'b0, 2);
        wait_valids(3, "period10");
        checks++;
        if (busy_len !== 100) begin
            errors++;
            $display("FAIL period10_busy_len: busy cycles=%0d, required 100", busy_len);
        end
    endtask

    task automatic test_constant();
        half = 0;
        level = 1'b0;
        push_exp(1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1);
        push_exp(1'b1, 16'd0, 1'b0, 16'd0, 1'b0, 2);
        wait_valids(3, "const0");
        level = 1'b1;
        push_exp(1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1);
        push_exp(1'b1, 16'd0, 1'b0, 16'd0, 1'b0, 2);
        wait_valids(3, "const1");
        checks++;
        if (gap_a !== 101) begin
            errors++;
            $display("FAIL const_spacing: gap=%0d, required 101", gap_a);
        end
    endtask

    task automatic test_abort();
        int nv;
        half = 1;
        push_exp(1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1);
        push_exp(1'b1, 16'd50, 1'b0, 16'd15, 1'b1, 1);
        wait_valids(2, "abort_pre");
        repeat (40) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: busy_a=%0b busy_b=%0b, required 0", busy_a, busy_b);
        end
        nv = n_va;
        repeat (150) @(negedge clk);
        checks++;
        if (n_va !== nv) begin
            errors++;
            $display("FAIL abort_no_valid: valids=%0d, required %0d", n_va, nv);
        end
        checks++;
        if (count_a !== 16'd50 || count_b !== 4'd15 || ovf_b !== 1'b1) begin
            errors++;
            $display("FAIL abort_hold: count_a=%0d count_b=%0d ovf_b=%0b, required 50 15 1",
                     count_a, count_b, ovf_b);
        end
        push_exp(1'b1, 16'd50, 1'b0, 16'd15, 1'b1, 1);
        enable = 1'b1;
        wait_valids(1, "abort_restart");
        checks++;
        if (busy_len !== 100) begin
            errors++;
            $display("FAIL abort_restart_busy: busy cycles=%0d, required 100", busy_len);
        end
    endtask

    task automatic test_reset_mid();
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({count_a, valid_a, ovf_a, busy_a, count_b, valid_b, ovf_b, busy_b} !== 26'd0) begin
                errors++;
                $display("FAIL reset_mid_outputs: a=%0d/%0b/%0b/%0b b=%0d/%0b/%0b/%0b, required all 0",
                         count_a, valid_a, ovf_a, busy_a, count_b, valid_b, ovf_b, busy_b);
            end
        end
        #3 rst_n = 1'b1;
        push_exp(1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1);
        push_exp(1'b1, 16'd50, 1'b0, 16'd15, 1'b1, 1);
        wait_valids(2, "reset_mid_restart");
    endtask

    initial begin
        test_reset();
        test_period2();
        test_period20();
        test_period10();
        test_constant();
        test_abort();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: qa=%0d qb=%0d, required 0", qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
Measures the frequency of a slow digital input, such as the output of the team's clock divider. It counts rising edges of `frequency` over a fixed gate window of GATE_CYCLES `clk` cycles and publishes the count with a one-cycle valid strobe. It is the receiving end of the divider path and provides self-check and observability of divided clocks in benches and on-chip.

Parameters:
GATE_CYCLES, 1000, length of the measurement window in clk cycles (>=2)
CNT_W, 16, width of the edge counter and result
SYNC_STAGES, 2, flops in the input synchroniser (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
enable  input  1  1 = run measurements back-to-back; 0 = stop/abort
frequency  input  1  signal under measurement, asynchronous to clk
count  output  CNT_W  rising edges counted in last completed window
valid  output  1  one-cycle pulse when count/overflow are updated
overflow  output  1  last completed window saturated the counter
busy  output  1  1 while a window is in progress

Behaviour:
- Reset (reset=0, async): state IDLE; count=0, valid=0, overflow=0, busy=0; sync chain, edge-detect flop, gate and edge counters all 0.
- Input path: `frequency` passes through SYNC_STAGES flops. A rise is seen when the last sync stage is 1 and the delayed copy is 0. Rise latency from the input pin is SYNC_STAGES+1 clk cycles.
- Correct counting requires `frequency` high and low each for at least 1 clk period (max f_clk/2).
- FSM states:
  - IDLE: busy=0. If enable=1, go to MEASURE next cycle and clear gate_cnt and edge_cnt.
  - MEASURE: busy=1. Each cycle gate_cnt++. On a rise, edge_cnt++ saturating at 2^CNT_W-1. An increment attempted at saturation sets the internal ovf flag. The window is exactly GATE_CYCLES cycles; a rise on the last cycle (gate_cnt==GATE_CYCLES-1) is counted. Then go to DONE.
  - DONE (1 cycle): count<=edge_cnt, overflow<=ovf, valid=1, busy=0. If enable=1, go to MEASURE with counters cleared; else go to IDLE. Rises during DONE are not counted (one dead cycle between windows).
- Abort: enable=0 in MEASURE → IDLE next cycle. No valid; count/overflow keep their previous values; counters cleared.
- Reset mid-window: immediate return to reset values; no valid is ever emitted for a partial window.
- count and overflow change only in DONE and reset; they are stable between valid pulses.
- Width rules: gate_cnt is $clog2(GATE_CYCLES) bits wide; edge_cnt is CNT_W bits wide with no wrap-around; ovf clears at window start.
- Simultaneous events: enable falling in the DONE cycle still publishes that result, then goes to IDLE.

Decomposition:
- Package freq_pkg: state encoding constants (IDLE, MEASURE, DONE), default GATE_CYCLES/CNT_W, shared with the divider bench.
- Sub-module sync_edge_det (parameter SYNC_STAGES; ports clk, reset, d, rise): synchroniser plus rising-edge detector, reusable by other async-input blocks.
- The top holds the FSM, gate counter, edge counter and output registers.

Test Plan:
- GATE_CYCLES=100, CNT_W=16; frequency toggles every clk edge-pair (period 2 clk); enable=1 → valid pulses every 101 cycles, count=50, overflow=0.
- Same setup, frequency period 10 clk (driven by the divider, divide-by-10) → count=10 on every window, busy=1 for exactly 100 cycles per window.
- CNT_W=4, GATE_CYCLES=100, period 2 → count=15, overflow=1. Then switch to period 20 → next window count=5, overflow=0.
- frequency held at 0, then held at 1 → count=0, valid still pulses every 101 cycles.
- enable dropped at window cycle 40 → busy=0 on the next cycle, no valid, count keeps prior value (e.g. 50). Re-enable → fresh full window.
- reset pulsed low for 3 cycles mid-window, asynchronous to clk → all outputs 0 while reset=0, no valid. Measurement restarts after release with enable=1.
